issue_ctrl: RTL
===============

Name: issue_ctrl

Overview:
- Issue controller sitting between the 19-bit field decoder and the execution units (ALU unit 0, L/S unit 1, CSR unit 2).
- Holds one decoded instruction in a single-entry holding register and routes it to the unit selected by `unit`.
- Serializes CSR accesses, fences and system instructions (ecall/ebreak/mret/illegal) behind outstanding L/S operations.
- Raises traps and flushes toward fetch.

Parameters:
- LSU_MAX_OUTST, 2, maximum number of L/S ops issued but not yet completed (1..7).
- CNT_W, 3, width of the outstanding-L/S counter; must satisfy 2^CNT_W > LSU_MAX_OUTST.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset
- kill  in  1  external flush (branch redirect); discards the held entry
- in_valid  in  1  decoded instruction valid
- in_ready  out  1  holding register can accept
- in_unit  in  2  decoder unit field
- in_sub_unit  in  3  decoder sub_unit field
- in_sel  in  3  decoder sel field
- in_imm  in  1  decoder imm flag
- in_fence  in  1  decoder fence flag
- in_ecall  in  1  decoder ecall flag
- in_ebreak  in  1  decoder ebreak flag
- in_mret  in  1  decoder mret flag
- in_illegal  in  1  decoder illegal_instr flag
- out_sub_unit  out  3  held sub_unit, driven to all units
- out_sel  out  3  held sel, driven to all units
- out_imm  out  1  held imm flag, driven to all units
- alu_valid  out  1  issue request to ALU
- alu_ready  in  1  ALU accept
- lsu_valid  out  1  issue request to L/S
- lsu_ready  in  1  L/S accept
- lsu_done  in  1  one-cycle pulse, one L/S op completed
- csr_valid  out  1  issue request to CSR
- csr_ready  in  1  CSR accept
- trap_valid  out  1  trap request
- trap_cause  out  2  trap cause: 0 ecall, 1 ebreak, 2 illegal, 3 mret
- trap_ack  in  1  trap accepted
- flush  out  1  one-cycle flush pulse to fetch
- stall_cnt  out  32  stall-cycle counter (see Optional Feature)

Behaviour:
- Reset is asynchronous and active-low on rst_n; the block uses the single clock clk.
- Reset values:
  - entry empty, state ISSUE, outstanding count 0;
  - all *_valid outputs 0, flush 0, trap_cause 0;
  - out_* fields 0, stall_cnt 0.
- Holding register:
  - Loads on in_valid && in_ready.
  - in_ready = !entry_v || fire, where fire means the entry retires this cycle. No extra bubble: back-to-back issue at 1 instr/cycle.
  - in_ready is 0 while state != ISSUE.
- Routing (state ISSUE, entry valid, no system flag):
  - unit 0 → alu_valid.
  - unit 1 → lsu_valid, only when count < LSU_MAX_OUTST.
  - unit 2 → csr_valid, only when count == 0.
  - Valid stays asserted until ready; the held fields are stable while valid is high.
  - unit 3 is never presented; the decoder flags it illegal.
- Outstanding counter:
  - +1 on lsu_valid && lsu_ready; -1 on lsu_done.
  - Both in the same cycle → unchanged.
  - lsu_done at count 0 is ignored; saturates at 0.
- Fence:
  - Waits for count == 0, then retires in one cycle with no unit valid.
  - fence.I (fence && imm) additionally pulses flush in the retire cycle.
- System instructions (ecall/ebreak/mret/illegal):
  - Priority when several flags are set: illegal > ebreak > ecall > mret.
  - State goes ISSUE → DRAIN (until count == 0) → TRAP.
  - In TRAP: trap_valid = 1 with trap_cause held until trap_ack.
  - On ack: entry cleared, flush pulses 1 cycle, state returns to ISSUE.
  - DRAIN is skipped when count is already 0; TRAP is entered the cycle after capture.
- kill:
  - Clears the entry and all *_valid outputs next cycle; returns to ISSUE from DRAIN.
  - Does not abort TRAP: a trap in progress completes first.
  - Does not affect the counter; in-flight L/S still return lsu_done.
  - kill together with in_valid: the new instruction is dropped.
- Reset mid-operation: everything returns to reset values immediately; in-flight lsu_done after reset are ignored at count 0.

Optional Feature:
- Macro: ISSUE_STALL_CNT_EN.
- Defined: stall_cnt increments every cycle the entry is valid but does not retire (unit not ready, LSU limit, CSR/fence drain, DRAIN, TRAP). It wraps at 2^32 and is cleared only by reset.
- Undefined: stall_cnt is tied to 0 and no counter flops are built.

Test Plan:
- ADD, SUB, ADDI back-to-back with alu_ready = 1 → alu_valid high 3 consecutive cycles; in_ready stays 1; out_sel = 0, 1, 0.
- 3 LW with lsu_ready = 1, no lsu_done, LSU_MAX_OUTST = 2 → 2 issued; third held with lsu_valid = 0; after one lsu_done, third issues next cycle; count reads 2.
- LW issued, then CSRRW → csr_valid stays 0 until lsu_done; csr_valid rises the cycle after count reaches 0.
- ecall with count = 1 → DRAIN; on lsu_done → trap_valid = 1, trap_cause = 0; trap_ack → flush pulse of 1 cycle; next instruction accepted.
- fence.I with count = 0 → retires in 1 cycle, flush = 1 for exactly 1 cycle, no unit valid.
- kill while lsu_valid held with lsu_ready = 0 → lsu_valid drops next cycle, count unchanged; with ISSUE_STALL_CNT_EN, stall_cnt equals the number of held cycles.

Source files
------------

// File: rtl/issue_ctrl.sv
// issue_ctrl: single-entry issue stage between the field decoder and the
// ALU (unit 0), L/S (unit 1) and CSR (unit 2) execution units.
// CSR accesses, fences and system instructions wait for outstanding L/S ops.
// Optional build macro: ISSUE_STALL_CNT_EN enables the 32-bit stall counter.
//
// Handshake: an issue request (alu/lsu/csr_valid) transfers on the cycle its
// ready is also high. Once raised, valid stays high and the out_* fields do not
// change until that transfer, or until kill clears the entry. in_valid/in_ready
// follow the same rule. trap_valid stays high until trap_ack.
module issue_ctrl #(
  parameter int LSU_MAX_OUTST = 2,
  parameter int CNT_W         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             kill,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_unit,
  input  logic [2:0]       in_sub_unit,
  input  logic [2:0]       in_sel,
  input  logic             in_imm,
  input  logic             in_fence,
  input  logic             in_ecall,
  input  logic             in_ebreak,
  input  logic             in_mret,
  input  logic             in_illegal,
  output logic [2:0]       out_sub_unit,
  output logic [2:0]       out_sel,
  output logic             out_imm,
  output logic             alu_valid,
  input  logic             alu_ready,
  output logic             lsu_valid,
  input  logic             lsu_ready,
  input  logic             lsu_done,
  output logic             csr_valid,
  input  logic             csr_ready,
  output logic             trap_valid,
  output logic [1:0]       trap_cause,
  input  logic             trap_ack,
  output logic             flush,
  output logic [31:0]      stall_cnt,
  output logic [1:0]       dbg_state,
  output logic [CNT_W-1:0] dbg_lsu_cnt
);

  typedef enum logic [1:0] {
    ST_ISSUE = 2'd0,
    ST_DRAIN = 2'd1,
    ST_TRAP  = 2'd2
  } state_t;

  state_t           state;
  logic             entry_v;
  logic [1:0]       e_unit;
  logic             e_fence;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  logic             in_sys;
  logic [1:0]       in_cause;
  logic             issue_ok;
  logic             fence_fire;
  logic             fire;
  logic             trap_done;
  logic             take;
  logic             lsu_inc;
  logic             lsu_dec;

  // Decode of the incoming system flags; illegal > ebreak > ecall > mret.
  always_comb begin
    in_sys   = in_ecall | in_ebreak | in_mret | in_illegal;
    in_cause = 2'd3;
    if (in_illegal)     in_cause = 2'd2;
    else if (in_ebreak) in_cause = 2'd1;
    else if (in_ecall)  in_cause = 2'd0;
  end

  // Routing, retire and handshake terms derived from the held entry.
  always_comb begin
    issue_ok   = (state == ST_ISSUE) && entry_v && !e_fence;
    alu_valid  = issue_ok && (e_unit == 2'd0);
    lsu_valid  = issue_ok && (e_unit == 2'd1) && (cnt < CNT_W'(LSU_MAX_OUTST));
    csr_valid  = issue_ok && (e_unit == 2'd2) && (cnt == '0);
    fence_fire = (state == ST_ISSUE) && entry_v && e_fence && (cnt == '0);
    // unit 3 only reaches here flagged illegal; retire it rather than hang.
    fire       = (alu_valid && alu_ready) || (lsu_valid && lsu_ready) ||
                 (csr_valid && csr_ready) || fence_fire ||
                 (issue_ok && (e_unit == 2'd3));
    trap_valid = (state == ST_TRAP);
    trap_done  = trap_valid && trap_ack;
    flush      = (fence_fire && out_imm) || trap_done;
    in_ready   = (state == ST_ISSUE) && (!entry_v || fire);
    take       = in_valid && in_ready && !kill;
    lsu_inc    = lsu_valid && lsu_ready;
    lsu_dec    = lsu_done && (cnt != '0);
    cnt_nxt    = cnt;
    if (lsu_inc && !lsu_dec)      cnt_nxt = cnt + 1'b1;
    else if (!lsu_inc && lsu_dec) cnt_nxt = cnt - 1'b1;
  end

  // Outstanding L/S counter; a done at zero is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else        cnt <= cnt_nxt;
  end

  // Issue FSM with the holding register and trap cause.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_ISSUE;
      entry_v      <= 1'b0;
      e_unit       <= 2'd0;
      e_fence      <= 1'b0;
      out_sub_unit <= 3'd0;
      out_sel      <= 3'd0;
      out_imm      <= 1'b0;
      trap_cause   <= 2'd0;
    end else begin
      case (state)
        ST_ISSUE: begin
          if (kill) begin
            entry_v <= 1'b0;
          end else if (take) begin
            entry_v      <= 1'b1;
            e_unit       <= in_unit;
            e_fence      <= in_fence && !in_sys;
            out_sub_unit <= in_sub_unit;
            out_sel      <= in_sel;
            out_imm      <= in_imm;
            if (in_sys) begin
              trap_cause <= in_cause;
              state      <= (cnt_nxt == '0) ? ST_TRAP : ST_DRAIN;
            end
          end else if (fire) begin
            entry_v <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (kill) begin
            entry_v <= 1'b0;
            state   <= ST_ISSUE;
          end else if (cnt == '0) begin
            state <= ST_TRAP;
          end
        end
        ST_TRAP: begin
          if (trap_ack) begin
            entry_v <= 1'b0;
            state   <= ST_ISSUE;
          end
        end
        default: state <= ST_ISSUE;
      endcase
    end
  end

  assign dbg_state   = state;
  assign dbg_lsu_cnt = cnt;

`ifdef ISSUE_STALL_CNT_EN
  // Count cycles where a held entry does not retire; wraps freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          stall_cnt <= 32'd0;
    else if (entry_v && !(fire || trap_done)) stall_cnt <= stall_cnt + 32'd1;
  end
`else
  assign stall_cnt = 32'd0;
`endif

endmodule
